// File: rtl/nrisk_sequencer.sv
// nrisk_sequencer
// Multi-cycle control sequencer for the nRisk 8-bit processor. Each instruction
// is stepped through FETCH, DECODE, EXECUTE, MEM and WRITEBACK. The sequencer
// drives the PC, instruction-register, register-file and memory strobes. It owns
// the single-port memory handshake, including a bounded wait, and it counts
// retired instructions.
//
// Ports:
//   clock         system clock, rising edge
//   reset_n       asynchronous active-low reset
//   run           start pulse, only looked at in IDLE
//   halt_req      return to IDLE once the current instruction retires
//   opcode        instruction bits [7:4], valid from DECODE onward
//   branch_taken  ALU branch condition, used in EXECUTE
//   mem_ack       memory completion, only meaningful while mem_req=1
//   mem_req       memory access request
//   mem_we        1 = store, 0 = read
//   mem_addr_sel  0 = PC, 1 = ALU result
//   ir_load       load instruction register
//   pc_write      update PC
//   pc_src        00 = PC+1, 01 = jump target, 10 = branch target
//   alu_en        ALU operation strobe
//   reg_write     register-file write enable
//   busy          high in every state except IDLE and ERROR
//   timeout_err   high in ERROR; stays set until reset
//   state_o       current state encoding
//   instr_count   retired-instruction counter, wraps

module nrisk_sequencer #(
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             run,
  input  logic             halt_req,
  input  logic [3:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_load,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_en,
  output logic             reg_write,
  output logic             busy,
  output logic             timeout_err,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEM       = 3'd4,
    WRITEBACK = 3'd5,
    ERROR     = 3'd7
  } state_t;

  // Last wait-counter value at which a missing ack still leaves us waiting;
  // a missing ack at this value means mem_req has been high TIMEOUT cycles.
  localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(TIMEOUT - 1);

  state_t          state;
  state_t          state_next;
  logic [TO_W-1:0] wait_cnt;
  logic [TO_W-1:0] wait_next;
  logic            retire;

  logic is_load;
  logic is_store;
  logic is_jump;
  logic is_branch;

  assign is_load   = (opcode == 4'b0100);
  assign is_store  = (opcode == 4'b0101);
  assign is_jump   = (opcode[3:1] == 3'b100);
  assign is_branch = (opcode[3:1] == 3'b111);

  assign state_o = state;

  // State, wait counter and retire counter. Reset drops the state to IDLE at
  // once, and because every strobe is decoded from the state, an access in
  // flight is abandoned without counting a retire.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      instr_count <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      if (retire) begin
        instr_count <= instr_count + 1'b1;
      end
    end
  end

  // Next-state and strobe decode. The wait counter only counts while a memory
  // access is pending and returns to zero otherwise, so it always starts from
  // zero on entry to FETCH or MEM. An ack in the last allowed cycle still
  // completes the access. Every retiring path funnels through 'retire', where
  // halt_req picks IDLE or the next FETCH.
  always_comb begin
    state_next   = state;
    wait_next    = '0;
    retire       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'b00;
    alu_en       = 1'b0;
    reg_write    = 1'b0;
    busy         = 1'b0;
    timeout_err  = 1'b0;

    case (state)
      IDLE: begin
        if (run) begin
          state_next = FETCH;
        end
      end

      FETCH: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_load    = 1'b1;
          state_next = DECODE;
        end else if (wait_cnt == WAIT_LAST) begin
          state_next = ERROR;
        end else begin
          wait_next = wait_cnt + 1'b1;
        end
      end

      DECODE: begin
        busy       = 1'b1;
        state_next = EXECUTE;
      end

      EXECUTE: begin
        busy   = 1'b1;
        alu_en = 1'b1;
        if (is_jump) begin
          pc_write = 1'b1;
          pc_src   = 2'b01;
          retire   = 1'b1;
        end else if (is_branch) begin
          pc_write = 1'b1;
          pc_src   = branch_taken ? 2'b10 : 2'b00;
          retire   = 1'b1;
        end else if (is_load || is_store) begin
          state_next = MEM;
        end else begin
          state_next = WRITEBACK;
        end
      end

      MEM: begin
        busy         = 1'b1;
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_store;
        if (mem_ack) begin
          if (is_store) begin
            pc_write = 1'b1;
            retire   = 1'b1;
          end else begin
            state_next = WRITEBACK;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          state_next = ERROR;
        end else begin
          wait_next = wait_cnt + 1'b1;
        end
      end

      WRITEBACK: begin
        busy      = 1'b1;
        reg_write = 1'b1;
        pc_write  = 1'b1;
        retire    = 1'b1;
      end

      ERROR: begin
        timeout_err = 1'b1;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (retire) begin
      state_next = halt_req ? IDLE : FETCH;
    end
  end

endmodule

// File: tb/tb_nrisk_sequencer.sv
// tb_nrisk_sequencer
// Drives nrisk_sequencer with directed and random instruction streams. Each
// instruction is expanded by a phase-level model into per-cycle inputs and
// expected outputs. A driver applies the inputs and queues the expectations,
// and a monitor pops and compares them on the falling edge.

module tb_nrisk_sequencer;

  localparam int TIMEOUT = 4;
  localparam int TO_W    = 4;
  localparam int CNT_W   = 16;

  logic             clock;
  logic             reset_n;
  logic             run;
  logic             halt_req;
  logic [3:0]       opcode;
  logic             branch_taken;
  logic             mem_ack;
  logic             mem_req;
  logic             mem_we;
  logic             mem_addr_sel;
  logic             ir_load;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             alu_en;
  logic             reg_write;
  logic             busy;
  logic             timeout_err;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] instr_count;

  // One planned cycle: inputs to drive plus the outputs expected in that cycle.
  // Output vector layout: state(3) req we asel irl pcw src(2) alu rw busy terr.
  typedef struct {
    logic             run;
    logic             halt;
    logic             ack;
    logic             bt;
    logic [3:0]       opc;
    logic [13:0]      expOut;
    logic [CNT_W-1:0] expCnt;
  } cycle_t;

  typedef struct {
    logic [13:0]      out;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  cycle_t plan[$];
  exp_t   expQ[$];
  int     checks;
  int     passes;
  int     modelCount;
  bit     modelIdle;
  bit     modelError;

  nrisk_sequencer #(
    .TIMEOUT(TIMEOUT),
    .TO_W   (TO_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .run         (run),
    .halt_req    (halt_req),
    .opcode      (opcode),
    .branch_taken(branch_taken),
    .mem_ack     (mem_ack),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr_sel(mem_addr_sel),
    .ir_load     (ir_load),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .alu_en      (alu_en),
    .reg_write   (reg_write),
    .busy        (busy),
    .timeout_err (timeout_err),
    .state_o     (state_o),
    .instr_count (instr_count)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic rnd();
    return ($urandom_range(0, 1) != 0);
  endfunction

  function automatic logic [13:0] actualOut();
    return {state_o, mem_req, mem_we, mem_addr_sel, ir_load, pc_write, pc_src,
            alu_en, reg_write, busy, timeout_err};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic addCycle(input logic r, input logic a, input logic b,
                          input logic [13:0] o, input logic [3:0] opc, input logic halt);
    cycle_t c;
    c.run    = r;
    c.halt   = halt;
    c.ack    = a;
    c.bt     = b;
    c.opc    = opc;
    c.expOut = o;
    c.expCnt = CNT_W'(modelCount);
    plan.push_back(c);
  endtask

  task automatic modelRetire(input logic halt);
    modelCount = (modelCount + 1) % (1 << CNT_W);
    modelIdle  = halt;
  endtask

  // Once the wait bound runs out the sequencer parks in ERROR; run is held
  // high there to show it is ignored.
  task automatic addError(input logic [3:0] opc);
    modelError = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addCycle(1'b1, rnd(), rnd(), {3'd7, 11'b0_0_0_0_0_00_0_0_0_1}, opc, rnd());
    end
  endtask

  // Expands one instruction into its cycles: wf/wm are ack wait cycles in
  // FETCH/MEM; a wait of TIMEOUT or more ends in ERROR.
  task automatic addInstr(input logic [3:0] opc, input int wf, input int wm,
                          input logic bt, input logic halt);
    logic ld;
    logic st;
    logic jp;
    logic br;
    ld = (opc == 4'b0100);
    st = (opc == 4'b0101);
    jp = (opc[3:1] == 3'b100);
    br = (opc[3:1] == 3'b111);
    if (modelError) return;
    if (modelIdle) begin
      addCycle(1'b1, rnd(), rnd(), {3'd0, 11'b0}, opc, halt);
      modelIdle = 1'b0;
    end
    for (int i = 0; i < wf && i < TIMEOUT; i++) begin
      addCycle(rnd(), 1'b0, rnd(), {3'd1, 11'b1_0_0_0_0_00_0_0_1_0}, opc, halt);
    end
    if (wf >= TIMEOUT) begin
      addError(opc);
      return;
    end
    addCycle(rnd(), 1'b1, rnd(), {3'd1, 11'b1_0_0_1_0_00_0_0_1_0}, opc, halt);
    addCycle(rnd(), rnd(), rnd(), {3'd2, 11'b0_0_0_0_0_00_0_0_1_0}, opc, halt);
    if (jp) begin
      addCycle(rnd(), rnd(), rnd(), {3'd3, 11'b0_0_0_0_1_01_1_0_1_0}, opc, halt);
      modelRetire(halt);
      return;
    end
    if (br) begin
      addCycle(rnd(), rnd(), bt, {3'd3, 4'b0000, 1'b1, (bt ? 2'b10 : 2'b00), 4'b1010}, opc, halt);
      modelRetire(halt);
      return;
    end
    addCycle(rnd(), rnd(), rnd(), {3'd3, 11'b0_0_0_0_0_00_1_0_1_0}, opc, halt);
    if (ld || st) begin
      for (int i = 0; i < wm && i < TIMEOUT; i++) begin
        addCycle(rnd(), 1'b0, rnd(), {3'd4, 1'b1, st, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0010}, opc, halt);
      end
      if (wm >= TIMEOUT) begin
        addError(opc);
        return;
      end
      addCycle(rnd(), 1'b1, rnd(), {3'd4, 1'b1, st, 1'b1, 1'b0, st, 2'b00, 4'b0010}, opc, halt);
      if (st) begin
        modelRetire(halt);
        return;
      end
    end
    addCycle(rnd(), rnd(), rnd(), {3'd5, 11'b0_0_0_0_1_00_0_1_1_0}, opc, halt);
    modelRetire(halt);
  endtask

  // Applies planned cycles just after each rising edge and queues their
  // expectations; optionally stops right after the first MEM cycle.
  task automatic applyStimulus(input bit stopAtMem);
    cycle_t c;
    exp_t   e;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      @(posedge clock);
      #1;
      run          = c.run;
      halt_req     = c.halt;
      mem_ack      = c.ack;
      branch_taken = c.bt;
      opcode       = c.opc;
      e.out        = c.expOut;
      e.cnt        = c.expCnt;
      expQ.push_back(e);
      if (stopAtMem && c.expOut[13:11] == 3'd4) break;
    end
    plan.delete();
  endtask

  // Asserts reset mid-cycle, checks that everything clears without a clock
  // edge, then releases it away from the rising edge.
  task automatic pulseReset(input string name);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput(name, {2'b00, actualOut(), instr_count}, 32'h0);
    run          = 1'b0;
    halt_req     = 1'b0;
    mem_ack      = 1'b0;
    branch_taken = 1'b0;
    modelCount   = 0;
    modelIdle    = 1'b1;
    modelError   = 1'b0;
    @(negedge clock);
    #2;
    reset_n = 1'b1;
  endtask

  // Monitor: compares the DUT against each queued expectation on the falling
  // edge, well away from the rising edge that moves the state.
  initial begin
    exp_t        e;
    logic [13:0] act;
    forever begin
      @(negedge clock);
      if (expQ.size() > 0) begin
        e   = expQ.pop_front();
        act = actualOut();
        checks++;
        if (act === e.out && instr_count === e.cnt) begin
          passes++;
        end else begin
          $display("[TB] FAIL cycle at %0t: got out=%b cnt=%0d, expected out=%b cnt=%0d",
                   $time, act, instr_count, e.out, e.cnt);
        end
      end
    end
  end

  // Main sequence: reset, directed instructions, a random stream, reset during
  // MEM, then fetch and memory timeouts each cleared by reset.
  initial begin
    checks       = 0;
    passes       = 0;
    modelCount   = 0;
    modelIdle    = 1'b1;
    modelError   = 1'b0;
    reset_n      = 1'b0;
    run          = 1'b0;
    halt_req     = 1'b0;
    mem_ack      = 1'b0;
    branch_taken = 1'b0;
    opcode       = 4'b0000;
    #3;
    checkOutput("reset state", {2'b00, actualOut(), instr_count}, 32'h0);
    @(negedge clock);
    #2;
    reset_n = 1'b1;

    addInstr(4'b0010, 0, 0, 1'b0, 1'b0);
    addInstr(4'b0100, 0, 2, 1'b0, 1'b0);
    addInstr(4'b0101, 1, 0, 1'b0, 1'b0);
    addInstr(4'b1110, 0, 0, 1'b1, 1'b0);
    addInstr(4'b1110, 0, 0, 1'b0, 1'b0);
    addInstr(4'b1000, 0, 0, 1'b0, 1'b0);
    addInstr(4'b0100, 1, 1, 1'b0, 1'b1);
    addInstr(4'b1001, TIMEOUT - 1, 0, 1'b0, 1'b0);
    addInstr(4'b0101, 0, TIMEOUT - 1, 1'b0, 1'b1);
    applyStimulus(1'b0);

    for (int i = 0; i < 60; i++) begin
      addInstr(4'($urandom_range(0, 15)), $urandom_range(0, TIMEOUT - 1),
               $urandom_range(0, TIMEOUT - 1), rnd(), ($urandom_range(0, 4) == 0));
    end
    applyStimulus(1'b0);

    addInstr(4'b0010, 0, 0, 1'b0, 1'b1);
    addInstr(4'b0100, 0, 3, 1'b0, 1'b0);
    applyStimulus(1'b1);
    pulseReset("reset during MEM");

    addInstr(4'b0011, 0, 0, 1'b0, 1'b0);
    addInstr(4'b0110, TIMEOUT, 0, 1'b0, 1'b0);
    applyStimulus(1'b0);
    pulseReset("reset from fetch ERROR");

    addInstr(4'b0101, 0, TIMEOUT, 1'b0, 1'b0);
    applyStimulus(1'b0);
    pulseReset("reset from mem ERROR");

    addInstr(4'b1111, 0, 0, 1'b1, 1'b1);
    applyStimulus(1'b0);

    repeat (3) @(negedge clock);
    #1;
    checkOutput("expectations drained", 32'(expQ.size()), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
